seg_scheduler: RTL
==================

SEG_SCHEDULER -- requirements
Module: seg_scheduler

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot, legal range >= 1.
REQ-002 SHALL have parameter HOLD_CYC, default 100000000: minimum clk cycles a granted message stays on the display, legal range >= 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port score, input, 16 bits: four BCD digits, digit0 = [3:0]; the always-available background source (owner 0).
REQ-006 SHALL have port timer_req, input, 1 bit: the timer source requests the display; level-sensitive.
REQ-007 SHALL have port timer_data, input, 16 bits: four timer digits, same packing as score.
REQ-008 SHALL have port msg_req, input, 1 bit: the message source requests the display; a pulse of one or more cycles counts.
REQ-009 SHALL have port msg_data, input, 16 bits: four message digits, same packing as score.
REQ-010 SHALL have port timer_gnt, output, 1 bit: high while the timer owns the display.
REQ-011 SHALL have port msg_gnt, output, 1 bit: high while the message owns the display.
REQ-012 SHALL have port owner, output, 2 bits: 0 = score, 1 = timer, 2 = message; value 3 is never driven.
REQ-013 SHALL have port seg_index, output, 4 bits: active-low digit enable.
REQ-014 SHALL have port digit, output, 4 bits: value of the currently enabled digit, for the external 7-seg decoder.

Function
REQ-015 Scan divider: counts 0..SCAN_DIV-1 and wraps; tick is asserted on the cycle the count equals SCAN_DIV-1. SCAN_DIV=1 gives a tick every cycle.
REQ-016 Digit pointer: 2 bits, advances by 1 on every tick, wrapping 3->0.
REQ-017 seg_index and digit update on the tick edge: pointer 0/1/2/3 -> seg_index 1110/1101/1011/0111, digit = frame_buf[4*ptr+3 : 4*ptr].
REQ-018 Frame boundary: the tick on which the pointer wraps 3->0.
REQ-019 At the frame boundary, frame_buf, owner and the grants SHALL update on that same edge, so digit0 of the new frame already shows the new owner's data.
REQ-020 Message latch: msg_pend is set on any cycle with msg_req=1 and cleared at the boundary that grants the message.
REQ-021 Hold counter: loaded with HOLD_CYC when the message is newly granted; thereafter decrements by 1 per cycle down to 0 and saturates there.
REQ-022 Arbitration at each boundary, first match wins:
- (a) owner=2 and hold counter != 0 -> message again;
- (b) msg_req or msg_pend -> message; the hold counter is reloaded only if the previous owner != 2;
- (c) timer_req -> timer;
- (d) otherwise -> score.
REQ-023 frame_buf SHALL be loaded at the boundary from the winning source's data as sampled that cycle; source data changes mid-frame are not visible until the next boundary.
REQ-024 Ownership changes occur only at frame boundaries; there is no mid-frame preemption, and a request change never tears a frame.
REQ-025 timer_gnt = (owner==1) and msg_gnt = (owner==2), both registered and updated on the same edge as owner.
REQ-026 msg_req deasserting during the hold SHALL NOT release the display; release happens at the first boundary with hold counter = 0 and no request.
REQ-027 msg_req held continuously SHALL keep the message owner; the hold counter is not reloaded while the owner stays 2.
REQ-028 timer_req dropping mid-frame SHALL keep the timer owner until the next boundary.

Reset
REQ-029 While rst_n=0 at a clock edge, the following SHALL be forced:
- seg_index=1111, digit=0, owner=0, timer_gnt=0, msg_gnt=0;
- pointer=3, scan count=0, frame_buf=score as sampled that cycle, msg_pend=0, hold counter=0.
REQ-030 Reset asserted mid-operation (any owner, any pointer) SHALL take effect on that edge; the first tick after release is a frame boundary.

Verification (SCAN_DIV=4, HOLD_CYC=40)
REQ-031 Reset then score=16'h1234, no requests -> seg_index=1111 until the first tick (4th cycle), then 1110/1101/1011/0111 with digit 4/3/2/1, 4 cycles each; frame period 16; owner=0.
REQ-032 timer_req=1, timer_data=16'h0059 raised during digit1 -> timer_gnt rises only at the next boundary; following frame shows digits 9,5,0,0; owner=1.
REQ-033 One-cycle msg_req pulse while timer owns, msg_data=16'hEEEE -> msg_gnt=1 at next boundary t0; still held at t0+16 and t0+32; at t0+48, with timer_req still 1, owner=1 and msg_gnt=0.
REQ-034 score changes 16'h1234 -> 16'h5678 while digit1 is shown -> digits 2,3 of that frame show 2,1; next frame shows 8,7,6,5.
REQ-035 msg_req and timer_req both rising on the boundary cycle -> owner=2, timer_gnt=0.
REQ-036 rst_n=0 for one cycle while owner=2 with hold pending -> next edge: seg_index=1111, owner=0, both grants 0; a stale msg_pend is not granted afterwards.

Source files
------------

// File: rtl/seg_scheduler.sv
// seg_scheduler: four-digit display scan with frame-aligned
// ownership arbitration between score, timer and message sources.
module seg_scheduler #(
    parameter int SCAN_DIV = 50000,
    parameter int HOLD_CYC = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score,
    input  logic        timer_req,
    input  logic [15:0] timer_data,
    input  logic        msg_req,
    input  logic [15:0] msg_data,
    output logic        timer_gnt,
    output logic        msg_gnt,
    output logic [1:0]  owner,
    output logic [3:0]  seg_index,
    output logic [3:0]  digit
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC);

    typedef enum logic [1:0] {
        OWN_SCORE = 2'd0,
        OWN_TIMER = 2'd1,
        OWN_MSG   = 2'd2
    } own_e;

    own_e          own_q;
    own_e          own_d;
    logic [CW-1:0] cnt;
    logic [1:0]    ptr;
    logic [1:0]    ptr_nxt;
    logic [15:0]   frame_buf;
    logic [15:0]   frame_nxt;
    logic [15:0]   win_data;
    logic          msg_pend;
    logic [HW-1:0] hold;
    logic          reload;
    logic          tick;
    logic          boundary;
    logic [3:0]    seg_nxt;
    logic [3:0]    dig_nxt;

    assign tick     = (cnt == CNT_MAX);
    assign boundary = tick && (ptr == 2'd3);
    assign ptr_nxt  = ptr + 2'd1;
    assign owner    = own_q;

    // Pick the next owner at a frame boundary, first match wins.
    always_comb begin
        own_d    = own_q;
        win_data = frame_buf;
        reload   = 1'b0;
        if (boundary) begin
            if (own_q == OWN_MSG && hold != '0) begin
                own_d    = OWN_MSG;
                win_data = msg_data;
            end else if (msg_req || msg_pend) begin
                own_d    = OWN_MSG;
                win_data = msg_data;
                reload   = (own_q != OWN_MSG);
            end else if (timer_req) begin
                own_d    = OWN_TIMER;
                win_data = timer_data;
            end else begin
                own_d    = OWN_SCORE;
                win_data = score;
            end
        end
    end

    // Select the enable pattern and digit shown after the next tick.
    always_comb begin
        frame_nxt = boundary ? win_data : frame_buf;
        seg_nxt   = 4'b1111;
        dig_nxt   = 4'h0;
        unique case (ptr_nxt)
            2'd0: begin
                seg_nxt = 4'b1110;
                dig_nxt = frame_nxt[3:0];
            end
            2'd1: begin
                seg_nxt = 4'b1101;
                dig_nxt = frame_nxt[7:4];
            end
            2'd2: begin
                seg_nxt = 4'b1011;
                dig_nxt = frame_nxt[11:8];
            end
            2'd3: begin
                seg_nxt = 4'b0111;
                dig_nxt = frame_nxt[15:12];
            end
        endcase
    end

    // Scan divider, digit pointer and the displayed digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            ptr       <= 2'd3;
            seg_index <= 4'b1111;
            digit     <= 4'h0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                ptr       <= ptr_nxt;
                seg_index <= seg_nxt;
                digit     <= dig_nxt;
            end
        end
    end

    // Ownership, grants and the latched frame contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            own_q     <= OWN_SCORE;
            timer_gnt <= 1'b0;
            msg_gnt   <= 1'b0;
            frame_buf <= score;
        end else begin
            own_q     <= own_d;
            timer_gnt <= (own_d == OWN_TIMER);
            msg_gnt   <= (own_d == OWN_MSG);
            frame_buf <= frame_nxt;
        end
    end

    // Message request latch and minimum-hold counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_pend <= 1'b0;
            hold     <= '0;
        end else begin
            if (boundary && own_d == OWN_MSG)
                msg_pend <= 1'b0;
            else if (msg_req)
                msg_pend <= 1'b1;
            if (reload)
                hold <= HOLD_LD;
            else if (hold != '0)
                hold <= hold - 1'b1;
        end
    end

endmodule
